// File: rtl/seg7_reader.sv
// Recovers a decimal digit from an asynchronous 7-segment bus: it synchronises the bus,
// debounces it, then classifies each stable pattern as digit 0-9, blank or illegal.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [6:0]       segIn,
  output logic [3:0]       digit,
  output logic             digitValid,
  output logic             blank,
  output logic             errorFlag,
  output logic             newDigit,
  output logic [CNT_W-1:0] acceptCount
);

  localparam int unsigned SC_W     = 4;
  localparam logic [SC_W-1:0] STABLE_N = SC_W'(STABLE_CYCLES);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [6:0]      s1, s2;
  logic [6:0]      cand, cand_nxt;
  logic [SC_W-1:0] cnt, cnt_nxt;
  logic [6:0]      accepted_pattern;
  logic            accept_c;
  logic            changed_c;
  logic [3:0]      dec_c;
  logic            is_digit_c;
  logic            is_blank_c;

  function automatic logic [3:0] decode(input logic [6:0] p);
    logic [3:0] d;
    case (p)
      7'h3F:   d = 4'd0;
      7'h06:   d = 4'd1;
      7'h5B:   d = 4'd2;
      7'h4F:   d = 4'd3;
      7'h66:   d = 4'd4;
      7'h6D:   d = 4'd5;
      7'h7D:   d = 4'd6;
      7'h07:   d = 4'd7;
      7'h7F:   d = 4'd8;
      7'h6F:   d = 4'd9;
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  // Two-flop synchroniser; nothing else looks at segIn.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= 7'd0;
      s2 <= 7'd0;
    end else begin
      s1 <= segIn;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= LOCKED;
      cand  <= 7'd0;
      cnt   <= STABLE_N;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Any change in s2 restarts the count, so the accept edge is the one that reaches STABLE_N.
  always_comb begin
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    state_nxt = state;
    accept_c  = 1'b0;
    if (s2 != cand) begin
      cand_nxt = s2;
      cnt_nxt  = SC_W'(1);
    end else if (state == SETTLE) begin
      cnt_nxt = cnt + SC_W'(1);
    end
    if (cnt_nxt == STABLE_N) begin
      state_nxt = LOCKED;
      accept_c  = (state == SETTLE) || (s2 != cand);
    end else begin
      state_nxt = SETTLE;
    end
  end

  always_comb begin
    dec_c      = decode(cand_nxt);
    is_digit_c = (dec_c != 4'hF);
    is_blank_c = (cand_nxt == 7'd0);
    changed_c  = accept_c && (cand_nxt != accepted_pattern);
  end

  // Classification outputs only move on an accept edge, so short glitches never reach them.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      digit            <= 4'hF;
      digitValid       <= 1'b0;
      blank            <= 1'b1;
      errorFlag        <= 1'b0;
      newDigit         <= 1'b0;
      acceptCount      <= CNT_W'(0);
      accepted_pattern <= 7'd0;
    end else begin
      newDigit <= changed_c;
      if (accept_c) begin
        digit      <= dec_c;
        digitValid <= is_digit_c;
        blank      <= is_blank_c;
        errorFlag  <= !is_digit_c && !is_blank_c;
      end
      if (changed_c) begin
        accepted_pattern <= cand_nxt;
        acceptCount      <= acceptCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: default debounce instance plus a STABLE_CYCLES=1 instance.
module tb_seg7_reader;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [6:0] segIn;
  logic [3:0] digit;
  logic       digitValid, blank, errorFlag, newDigit;
  logic [7:0] acceptCount;

  logic [6:0] seg1;
  logic [3:0] d1_digit;
  logic       d1_digitValid, d1_blank, d1_errorFlag, d1_newDigit;
  logic [7:0] d1_acceptCount;

  int nvec = 0;
  int nerr = 0;
  int pulses = 0;
  int exp_count = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .segIn(segIn),
    .digit(digit), .digitValid(digitValid), .blank(blank), .errorFlag(errorFlag),
    .newDigit(newDigit), .acceptCount(acceptCount)
  );

  seg7_reader #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .segIn(seg1),
    .digit(d1_digit), .digitValid(d1_digitValid), .blank(d1_blank), .errorFlag(d1_errorFlag),
    .newDigit(d1_newDigit), .acceptCount(d1_acceptCount)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (newDigit === 1'b1) pulses <= pulses + 1;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    int p0;
    RESET_N = 1'b0;
    segIn = 7'h00;
    seg1 = 7'h00;
    repeat (2) @(posedge CLOCK_50);
    #1;
    nvec++; if (digit !== 4'hF || digitValid !== 1'b0) begin nerr++; $display("FAIL reset_digit: got %h/%b want f/0", digit, digitValid); end
    nvec++; if (blank !== 1'b1 || errorFlag !== 1'b0) begin nerr++; $display("FAIL reset_class: got blank=%b err=%b want 1/0", blank, errorFlag); end
    nvec++; if (newDigit !== 1'b0 || acceptCount !== 8'd0) begin nerr++; $display("FAIL reset_cnt: got nd=%b cnt=%0d want 0/0", newDigit, acceptCount); end
    nvec++; if (d1_blank !== 1'b1 || d1_digit !== 4'hF) begin nerr++; $display("FAIL reset_d1: got blank=%b digit=%h want 1/f", d1_blank, d1_digit); end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    p0 = pulses;
    repeat (20) tick();
    nvec++; if (blank !== 1'b1 || digit !== 4'hF || digitValid !== 1'b0) begin nerr++; $display("FAIL blank_hold: got blank=%b digit=%h valid=%b want 1/f/0", blank, digit, digitValid); end
    nvec++; if (pulses - p0 !== 0 || acceptCount !== 8'd0) begin nerr++; $display("FAIL blank_nopulse: got pulses=%0d cnt=%0d want 0/0", pulses - p0, acceptCount); end
  endtask

  task automatic test_digits();
    logic [3:0] prev;
    int p0;
    prev = 4'hF;
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      segIn = pat[i];
      repeat (5) tick();
      nvec++; if (digit !== prev) begin nerr++; $display("FAIL digit_hold[%0d]: got %h want %h", i, digit, prev); end
      tick();
      nvec++; if (digit !== 4'(i) || digitValid !== 1'b1 || blank !== 1'b0) begin nerr++; $display("FAIL digit_val[%0d]: got %h/%b/%b want %h/1/0", i, digit, digitValid, blank, 4'(i)); end
      nvec++; if (newDigit !== 1'b1) begin nerr++; $display("FAIL digit_pulse[%0d]: got %b want 1", i, newDigit); end
      tick();
      nvec++; if (newDigit !== 1'b0) begin nerr++; $display("FAIL digit_pulse_end[%0d]: got %b want 0", i, newDigit); end
      repeat (3) tick();
      prev = 4'(i);
      exp_count++;
    end
    nvec++; if (acceptCount !== 8'(exp_count) || pulses - p0 !== 10) begin nerr++; $display("FAIL digit_count: got cnt=%0d pulses=%0d want %0d/10", acceptCount, pulses - p0, exp_count); end
  endtask

  task automatic test_glitch();
    int p0;
    segIn = 7'h5B;
    repeat (10) tick();
    exp_count++;
    nvec++; if (digit !== 4'd2 || acceptCount !== 8'(exp_count)) begin nerr++; $display("FAIL glitch_pre: got digit=%h cnt=%0d want 2/%0d", digit, acceptCount, exp_count); end
    p0 = pulses;
    segIn = 7'h7F;
    repeat (3) tick();
    segIn = 7'h5B;
    repeat (3) tick();
    nvec++; if (digit !== 4'd2 || digitValid !== 1'b1) begin nerr++; $display("FAIL glitch_mid: got digit=%h valid=%b want 2/1", digit, digitValid); end
    repeat (7) tick();
    nvec++; if (digit !== 4'd2 || acceptCount !== 8'(exp_count)) begin nerr++; $display("FAIL glitch_post: got digit=%h cnt=%0d want 2/%0d", digit, acceptCount, exp_count); end
    nvec++; if (pulses - p0 !== 0) begin nerr++; $display("FAIL glitch_pulse: got %0d pulses want 0", pulses - p0); end
  endtask

  task automatic test_error();
    int p0;
    p0 = pulses;
    segIn = 7'h49;
    repeat (10) tick();
    exp_count++;
    nvec++; if (errorFlag !== 1'b1 || digit !== 4'hF || digitValid !== 1'b0 || blank !== 1'b0) begin nerr++; $display("FAIL error_class: got err=%b digit=%h valid=%b blank=%b want 1/f/0/0", errorFlag, digit, digitValid, blank); end
    nvec++; if (pulses - p0 !== 1 || acceptCount !== 8'(exp_count)) begin nerr++; $display("FAIL error_pulse: got pulses=%0d cnt=%0d want 1/%0d", pulses - p0, acceptCount, exp_count); end
    segIn = 7'h4F;
    repeat (10) tick();
    exp_count++;
    nvec++; if (digit !== 4'd3 || errorFlag !== 1'b0 || digitValid !== 1'b1) begin nerr++; $display("FAIL error_clear: got digit=%h err=%b valid=%b want 3/0/1", digit, errorFlag, digitValid); end
  endtask

  task automatic test_toggle();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      segIn = (i % 2 == 0) ? 7'h06 : 7'h4F;
      tick();
      nvec++; if (digit !== 4'd3 || newDigit !== 1'b0) begin nerr++; $display("FAIL toggle_hold[%0d]: got digit=%h nd=%b want 3/0", i, digit, newDigit); end
    end
    repeat (10) tick();
    nvec++; if (pulses - p0 !== 0 || acceptCount !== 8'(exp_count)) begin nerr++; $display("FAIL toggle_count: got pulses=%0d cnt=%0d want 0/%0d", pulses - p0, acceptCount, exp_count); end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - exp_count;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        nvec++; if (acceptCount !== 8'd255) begin nerr++; $display("FAIL wrap_pre: got %0d want 255", acceptCount); end
      end
      segIn = (i % 2 == 0) ? 7'h06 : 7'h66;
      repeat (7) tick();
    end
    exp_count = 0;
    nvec++; if (acceptCount !== 8'd0) begin nerr++; $display("FAIL wrap_zero: got %0d want 0", acceptCount); end
    nvec++; if (digit !== ((n % 2 == 1) ? 4'd1 : 4'd4)) begin nerr++; $display("FAIL wrap_digit: got %h", digit); end
  endtask

  task automatic test_stable1();
    seg1 = 7'h7D;
    repeat (2) tick();
    nvec++; if (d1_digit !== 4'hF || d1_blank !== 1'b1) begin nerr++; $display("FAIL s1_hold: got digit=%h blank=%b want f/1", d1_digit, d1_blank); end
    tick();
    nvec++; if (d1_digit !== 4'd6 || d1_digitValid !== 1'b1 || d1_errorFlag !== 1'b0) begin nerr++; $display("FAIL s1_accept: got digit=%h valid=%b err=%b want 6/1/0", d1_digit, d1_digitValid, d1_errorFlag); end
    nvec++; if (d1_newDigit !== 1'b1 || d1_acceptCount !== 8'd1) begin nerr++; $display("FAIL s1_pulse: got nd=%b cnt=%0d want 1/1", d1_newDigit, d1_acceptCount); end
    tick();
    nvec++; if (d1_newDigit !== 1'b0) begin nerr++; $display("FAIL s1_pulse_end: got %b want 0", d1_newDigit); end
  endtask

  task automatic test_reset_mid();
    segIn = 7'h07;
    repeat (3) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    nvec++; if (digit !== 4'hF || digitValid !== 1'b0 || blank !== 1'b1 || errorFlag !== 1'b0) begin nerr++; $display("FAIL rstmid_class: got digit=%h valid=%b blank=%b err=%b want f/0/1/0", digit, digitValid, blank, errorFlag); end
    nvec++; if (acceptCount !== 8'd0 || newDigit !== 1'b0) begin nerr++; $display("FAIL rstmid_cnt: got cnt=%0d nd=%b want 0/0", acceptCount, newDigit); end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (5) tick();
    nvec++; if (digit !== 4'hF || blank !== 1'b1) begin nerr++; $display("FAIL rstmid_edge5: got digit=%h blank=%b want f/1", digit, blank); end
    tick();
    nvec++; if (digit !== 4'd7 || digitValid !== 1'b1 || newDigit !== 1'b1 || acceptCount !== 8'd1) begin nerr++; $display("FAIL rstmid_edge6: got digit=%h valid=%b nd=%b cnt=%0d want 7/1/1/1", digit, digitValid, newDigit, acceptCount); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_glitch();
    test_error();
    test_toggle();
    test_wrap();
    test_stable1();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
